// File: rtl/match_priority_encoder.sv
// Lowest-index-wins priority encoder for table match vectors, with any/multi-match flags
// and a sticky multi-match error. Define ENCODER_REG_OUT_EN to register out/valid/multi.
module match_priority_encoder #(
    parameter int WIDTH     = 8,
    parameter int OUT_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in,
    input  logic                 clear_err,
    output logic [OUT_WIDTH-1:0] out,
    output logic                 valid,
    output logic                 multi,
    output logic                 multi_err
);

    generate
        if (WIDTH < 2 || WIDTH > 64 || OUT_WIDTH != $clog2(WIDTH)) begin : g_param_check
            $fatal(1, "match_priority_encoder: illegal WIDTH/OUT_WIDTH combination");
        end
    endgenerate

    logic [OUT_WIDTH-1:0] idx_c;
    logic                 valid_c;
    logic                 multi_c;

    always_comb begin
        // NOTE: default assigned first so every path drives idx_c; no latch is inferred.
        idx_c = '0;
        // Scan downward so the lowest set bit is the last (winning) assignment.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (in[i]) begin
                idx_c = OUT_WIDTH'(i);
            end
        end
    end

    assign valid_c = |in;
    // Clearing the lowest set bit leaves something only when two or more bits were set.
    assign multi_c = |(in & (in - WIDTH'(1)));

`ifdef ENCODER_REG_OUT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            out   <= '0;
            valid <= 1'b0;
            multi <= 1'b0;
        end else begin
            out   <= idx_c;
            valid <= valid_c;
            multi <= multi_c;
        end
    end
`else
    assign out   = idx_c;
    assign valid = valid_c;
    assign multi = multi_c;
`endif

    // Sticky error: reset beats clear, clear beats a simultaneous set.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment for all state so every flop samples pre-edge values.
        if (!reset) begin
            multi_err <= 1'b0;
        end else if (clear_err) begin
            multi_err <= 1'b0;
        end else if (multi_c) begin
            multi_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_match_priority_encoder.sv
// Scoreboard bench for match_priority_encoder; expectations come from a reference model
// and are queued when stimulus is driven, then popped when the DUT output is due.
module tb_match_priority_encoder;

    typedef struct packed {
        logic [2:0] idx;
        logic       vld;
        logic       mlt;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [7:0] in_vec;
    logic       clear_err;
    logic [2:0] out;
    logic       valid;
    logic       multi;
    logic       multi_err;

    int   checks;
    int   errors;
    logic err_m;
    exp_t sb[$];

    match_priority_encoder #(.WIDTH(8), .OUT_WIDTH(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in_vec),
        .clear_err (clear_err),
        .out       (out),
        .valid     (valid),
        .multi     (multi),
        .multi_err (multi_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (in=%02h)", tag, got, exp, in_vec);
        end
    endtask

    function automatic exp_t model(input logic [7:0] v);
        exp_t e;
        int   cnt;
        bit   found;
        e     = '0;
        cnt   = 0;
        found = 0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                if (!found) begin
                    e.idx = 3'(i);
                    found = 1;
                end
                cnt++;
            end
        end
        e.vld = (v != 8'h00);
        e.mlt = (cnt >= 2);
        return e;
    endfunction

    task automatic compare_outputs();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 8'd1, 8'd0);
        end else begin
            e = sb.pop_front();
            check("out", 8'(out), 8'(e.idx));
            check("valid", 8'(valid), 8'(e.vld));
            check("multi", 8'(multi), 8'(e.mlt));
        end
    endtask

    // Drive one cycle of stimulus at negedge; outputs and multi_err are compared
    // just after the following rising edge (plus right after drive when combinational).
    task automatic step(input logic [7:0] v, input logic clr, input logic rst_v);
        exp_t e;
        @(negedge clk);
        in_vec    = v;
        clear_err = clr;
        reset     = rst_v;
        e = model(v);
`ifdef ENCODER_REG_OUT_EN
        if (!rst_v) e = '0;
        sb.push_back(e);
`else
        sb.push_back(e);
        #1;
        compare_outputs();
        sb.push_back(e);
`endif
        @(posedge clk);
        if (!rst_v)          err_m = 1'b0;
        else if (clr)        err_m = 1'b0;
        else if (model(v).mlt) err_m = 1'b1;
        #1;
        check("multi_err", 8'(multi_err), 8'(err_m));
        compare_outputs();
    endtask

    initial begin
        logic [7:0] v;
        clk       = 1'b0;
        reset     = 1'b0;
        in_vec    = 8'h00;
        clear_err = 1'b0;
        checks    = 0;
        errors    = 0;
        err_m     = 1'b0;

        // Reset state, including a multi-hot input held during reset.
        step(8'h00, 1'b0, 1'b0);
        step(8'hFF, 1'b0, 1'b0);

        // Single-hot sweep.
        for (int j = 0; j < 8; j++) step(8'(1 << j), 1'b0, 1'b1);

        // Zero input for five clocks: no error accumulates.
        for (int k = 0; k < 5; k++) step(8'h00, 1'b0, 1'b1);

        // Multi-match sets the sticky error; it survives a return to single-hot.
        step(8'b1010_0000, 1'b0, 1'b1);
        step(8'h01, 1'b0, 1'b1);
        step(8'h01, 1'b0, 1'b1);

        // Clear pulse, then clear wins over a simultaneous set.
        step(8'h01, 1'b1, 1'b1);
        step(8'hFF, 1'b1, 1'b1);
        step(8'hFF, 1'b0, 1'b1);

        // Mid-operation reset discards the error history.
        step(8'h0C, 1'b0, 1'b0);
        step(8'h0C, 1'b0, 1'b1);
        step(8'h24, 1'b0, 1'b1);

        // Random traffic with occasional clear and reset.
        for (int n = 0; n < 1000; n++) begin
            case ($urandom_range(0, 3))
                0:       v = 8'h00;
                1:       v = 8'(1 << $urandom_range(0, 7));
                default: v = 8'($urandom);
            endcase
            step(v, ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
